mmio_side_effects: RTL

- Sequential memory-mapped I/O backend for the 3-stage RISC-V core.
- Owns the four performance counters (cycle, retired instruction, branch, correct-prediction) that the stage-3 control block selects for MMIO reads.
- Performs all I/O side effects issued by the stage-2 memory access: UART transmit write, UART receive consume, and counter reset.
- Sits beside the memory address path in stage 2; its counter outputs feed the stage-3 io_value mux.

---
 rtl/mmio_side_effects_pkg.sv | 24 ++
 rtl/mmio_side_effects_perf_counter.sv | 33 +++
 rtl/mmio_side_effects.sv | 110 +++++++++++
 3 files changed

// File: rtl/mmio_side_effects_pkg.sv
// Shared constants for the MMIO side-effect backend: register map and TX FSM encodings.
package mmio_side_effects_pkg;

    localparam logic [31:0] UART_CTRL = 32'h8000_0000;
    localparam logic [31:0] UART_RX   = 32'h8000_0004;
    localparam logic [31:0] UART_TX   = 32'h8000_0008;
    localparam logic [31:0] CYC       = 32'h8000_0010;
    localparam logic [31:0] INSTR     = 32'h8000_0014;
    localparam logic [31:0] CNT_RST   = 32'h8000_0018;
    localparam logic [31:0] BR        = 32'h8000_001c;
    localparam logic [31:0] BR_OK     = 32'h8000_0020;

    // Register offsets from the MMIO base, so a relocated IO_BASE keeps the same map.
    localparam logic [31:0] DEFAULT_BASE = UART_CTRL;
    localparam logic [31:0] UART_RX_OFF  = UART_RX - DEFAULT_BASE;
    localparam logic [31:0] UART_TX_OFF  = UART_TX - DEFAULT_BASE;
    localparam logic [31:0] CNT_RST_OFF  = CNT_RST - DEFAULT_BASE;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/mmio_side_effects_perf_counter.sv
// Free-running event counter with synchronous reset and a clear that wins over increment.
module mmio_side_effects_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mmio_side_effects.sv
// Stage-2 MMIO backend: UART TX/RX side effects and the four performance counters.
//
//   state   | meaning
//   TX_IDLE | no byte waiting; uart_tx_valid low
//   TX_PEND | byte held in uart_tx_data; uart_tx_valid high until accepted
module mmio_side_effects
    import mmio_side_effects_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'h8000_0000,
    parameter int          CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      mem_addr_s2,
    input  logic [31:0]      mem_wdata_s2,
    input  logic [3:0]       mem_we_s2,
    input  logic             mem_re_s2,
    input  logic             instr_valid_s3,
    input  logic             is_branch_s2,
    input  logic             br_taken_s2,
    input  logic             br_pred_taken_s2,
    input  logic             uart_tx_ready,
    output logic [7:0]       uart_tx_data,
    output logic             uart_tx_valid,
    output logic             uart_rx_ready,
    output logic [CNT_W-1:0] cyc_counter,
    output logic [CNT_W-1:0] instr_counter,
    output logic [CNT_W-1:0] br_instr_counter,
    output logic [CNT_W-1:0] correct_br_counter
);

    logic      is_store, tx_wr, rx_rd, cnt_clr, tx_accept;
    logic      br_evt, br_ok_evt, instr_evt;
    tx_state_e tx_state_q, tx_state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic      rx_ready_q, rx_ready_d;
    logic      unused_wdata;

    // Byte enables are deliberately ignored: any nonzero mask is a store.
    assign is_store = !stall && (mem_we_s2 != 4'b0000);
    assign tx_wr    = is_store && (mem_addr_s2 == IO_BASE + UART_TX_OFF);
    assign cnt_clr  = is_store && (mem_addr_s2 == IO_BASE + CNT_RST_OFF);
    assign rx_rd    = !stall && mem_re_s2 && (mem_addr_s2 == IO_BASE + UART_RX_OFF);

    assign instr_evt = instr_valid_s3 && !stall;
    assign br_evt    = is_branch_s2 && !stall;
    assign br_ok_evt = br_evt && (br_taken_s2 == br_pred_taken_s2);

    assign tx_accept    = (tx_state_q == TX_PEND) && uart_tx_ready;
    assign unused_wdata = ^mem_wdata_s2[31:8];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        rx_ready_d = rx_rd;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_wr) begin
                    tx_state_d = TX_PEND;
                    tx_data_d  = mem_wdata_s2[7:0];
                end
            end
            TX_PEND: begin
                // A write while the old byte is still unaccepted is dropped.
                if (tx_accept) begin
                    if (tx_wr) begin
                        tx_data_d = mem_wdata_s2[7:0];
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_data_q  <= 8'h00;
            rx_ready_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign uart_tx_valid = (tx_state_q == TX_PEND);
    assign uart_tx_data  = tx_data_q;
    assign uart_rx_ready = rx_ready_q;

    mmio_side_effects_perf_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk(clk), .rst(rst), .inc(1'b1), .clr(cnt_clr), .count(cyc_counter)
    );

    mmio_side_effects_perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .clk(clk), .rst(rst), .inc(instr_evt), .clr(cnt_clr), .count(instr_counter)
    );

    mmio_side_effects_perf_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk(clk), .rst(rst), .inc(br_evt), .clr(cnt_clr), .count(br_instr_counter)
    );

    mmio_side_effects_perf_counter #(.CNT_W(CNT_W)) u_br_ok_cnt (
        .clk(clk), .rst(rst), .inc(br_ok_evt), .clr(cnt_clr), .count(correct_br_counter)
    );

endmodule
